// File: rtl/melody_sequencer_if.sv
// Control/table-programming bus between the switch logic and the melody sequencer,
// plus the note/status outputs toward the note lookup and tone generator.
interface melody_sequencer_if;
    logic       start;
    logic       stop;
    logic       loop;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] note_code;
    logic       tone_en;
    logic       busy;
    logic [3:0] step_idx;
    logic       done;

    modport master (
        output start, stop, loop, wr_en, wr_addr, wr_data,
        input  note_code, tone_en, busy, step_idx, done
    );

    modport slave (
        input  start, stop, loop, wr_en, wr_addr, wr_data,
        output note_code, tone_en, busy, step_idx, done
    );
endinterface

// File: rtl/melody_sequencer.sv
// Steps a programmable {dur, note} table: each entry sounds for dur beats,
// then an optional silent gap, then the next entry (or wrap / finish).
module melody_sequencer #(
    parameter int SEQ_LEN  = 16,
    parameter int BEAT_DIV = 12_500_000,
    parameter int GAP_DIV  = 1_250_000
) (
    input  logic              clk,
    input  logic              rst,
    melody_sequencer_if.slave bus
);
    localparam int              CW        = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam int              GW        = (GAP_DIV > 1) ? $clog2(GAP_DIV) : 1;
    localparam logic [CW-1:0]   BEAT_LAST = CW'(BEAT_DIV - 1);
    localparam logic [GW-1:0]   GAP_LAST  = GW'((GAP_DIV > 0) ? GAP_DIV - 1 : 0);
    localparam logic [4:0]      SEQ_END   = 5'(SEQ_LEN);
    localparam logic            GAP_NONE  = (GAP_DIV == 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_r;
    logic [7:0]      tbl_r [16];
    logic [CW-1:0]   cyc_cnt_r;
    logic [GW-1:0]   gap_cnt_r;
    logic [3:0]      beats_r;
    logic [3:0]      note_code_r;
    logic [3:0]      step_idx_r;
    logic            tone_en_r;
    logic            busy_r;
    logic            done_r;

    logic [4:0]      next_idx_s;
    logic            seq_end_s;
    logic            play_end_s;
    logic            gap_end_s;
    logic            launch_s;
    logic            tgt_ok_s;
    logic [3:0]      tgt_idx_s;
    logic [7:0]      tgt_entry_s;

    // Advance decision: which entry (if any) the next PLAY should load.
    always_comb begin
        next_idx_s  = {1'b0, step_idx_r} + 5'd1;
        seq_end_s   = (next_idx_s == SEQ_END) || (tbl_r[next_idx_s[3:0]][7:4] == 4'd0);
        play_end_s  = (state_r == PLAY) && (cyc_cnt_r == BEAT_LAST) && (beats_r == 4'd1);
        gap_end_s   = (state_r == GAP) && (gap_cnt_r == GAP_LAST);
        launch_s    = ((state_r == IDLE) && bus.start) || (play_end_s && GAP_NONE) || gap_end_s;
        if (state_r == IDLE) begin
            tgt_idx_s = 4'd0;
            tgt_ok_s  = (tbl_r[0][7:4] != 4'd0);
        end else if (seq_end_s) begin
            tgt_idx_s = 4'd0;
            tgt_ok_s  = bus.loop && (tbl_r[0][7:4] != 4'd0);
        end else begin
            tgt_idx_s = next_idx_s[3:0];
            tgt_ok_s  = 1'b1;
        end
        tgt_entry_s = tbl_r[tgt_idx_s];
    end

    // Table storage, sequencing FSM, beat/gap counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cyc_cnt_r   <= '0;
            gap_cnt_r   <= '0;
            beats_r     <= 4'd0;
            note_code_r <= 4'd0;
            step_idx_r  <= 4'd0;
            tone_en_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                tbl_r[i] <= 8'h00;
            end
        end else begin
            if (bus.wr_en && ({1'b0, bus.wr_addr} < SEQ_END)) begin
                tbl_r[bus.wr_addr] <= bus.wr_data;
            end
            done_r <= 1'b0;
            if (bus.stop) begin
                state_r     <= IDLE;
                note_code_r <= 4'd0;
                tone_en_r   <= 1'b0;
                busy_r      <= 1'b0;
            end else if (launch_s) begin
                // Entry is sampled here, so a write to it this cycle only affects later visits.
                if (tgt_ok_s) begin
                    state_r     <= PLAY;
                    step_idx_r  <= tgt_idx_s;
                    note_code_r <= tgt_entry_s[3:0];
                    tone_en_r   <= (tgt_entry_s[3:0] != 4'd0);
                    busy_r      <= 1'b1;
                    beats_r     <= tgt_entry_s[7:4];
                    cyc_cnt_r   <= '0;
                end else begin
                    state_r     <= DONE;
                    done_r      <= 1'b1;
                    note_code_r <= 4'd0;
                    tone_en_r   <= 1'b0;
                    busy_r      <= 1'b0;
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    PLAY: begin
                        if (play_end_s) begin
                            state_r     <= GAP;
                            gap_cnt_r   <= '0;
                            note_code_r <= 4'd0;
                            tone_en_r   <= 1'b0;
                        end else if (cyc_cnt_r == BEAT_LAST) begin
                            cyc_cnt_r <= '0;
                            beats_r   <= beats_r - 4'd1;
                        end else begin
                            cyc_cnt_r <= cyc_cnt_r + CW'(1);
                        end
                    end
                    GAP: begin
                        gap_cnt_r <= gap_cnt_r + GW'(1);
                    end
                    DONE: begin
                        state_r <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.note_code = note_code_r;
    assign bus.tone_en   = tone_en_r;
    assign bus.busy      = busy_r;
    assign bus.step_idx  = step_idx_r;
    assign bus.done      = done_r;
endmodule
